// File: rtl/cpu_bus_frontend.sv
// cpu_bus_frontend
//   Brings asynchronous CPU bus strobes into the FPGA clock domain, waits until an access
//   has been stable long enough, and then runs a req/ack handshake with the back-end memory.
//   The block holds the CPU with cpu_wait until the back end answers or the timeout expires.
//   One RTL block serves both Z80 (mreq/rd/wr) and 6502-style (phi2, r/w) buses.
//
// Parameters
//   ADDR_W, DATA_W  CPU address and data widths
//   CPU_MODE        0 = Z80 strobes, 1 = phi2 + R/W
//   SYNC_STAGES     synchroniser depth (2..4)
//   SETTLE_CYC      clocks of stable strobe before the access is issued (1..15)
//   TIMEOUT_CYC     clocks in REQ without acc_ack before abort (1..4095)
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   cpu_addr, cpu_din          CPU address and write data (asynchronous)
//   cpu_dout, cpu_doe          read data to the CPU and its output enable
//   cpu_rd_n/wr_n/mreq_n/ioreq_n   Z80 strobes (mode 0)
//   cpu_phi2, cpu_rwb          6502-style strobes (mode 1)
//   cpu_wait                   wait request to the CPU, active-high
//   acc_req/addr/wdata/we/io   back-end request and latched access attributes
//   acc_ack, acc_rdata         back-end single-cycle ack and read data
//   err_timeout                sticky timeout flag, cleared only by reset
//
// Build option
//   IO_CYCLE_EN  when defined, Z80 I/O cycles (ioreq with mreq high) are accesses too and
//                are flagged on acc_io; otherwise cpu_ioreq_n is ignored.

module cpu_bus_frontend #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CPU_MODE    = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_doe,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic              cpu_mreq_n,
    input  logic              cpu_ioreq_n,
    input  logic              cpu_phi2,
    input  logic              cpu_rwb,
    output logic              cpu_wait,
    output logic              acc_req,
    output logic [ADDR_W-1:0] acc_addr,
    output logic [DATA_W-1:0] acc_wdata,
    output logic              acc_we,
    output logic              acc_io,
    input  logic              acc_ack,
    input  logic [DATA_W-1:0] acc_rdata,
    output logic              err_timeout
);

    typedef enum logic [1:0] {StIdle, StSettle, StReq, StHold} state_e;

    // Raw (asynchronous) bus decode.
    logic raw_act, raw_wr, raw_io;

    always_comb begin
        raw_io = 1'b0;
        if (CPU_MODE == 0) begin
            raw_act = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
            // Both rd_n and wr_n low counts as a write.
            raw_wr  = !cpu_wr_n;
`ifdef IO_CYCLE_EN
            // Interrupt acknowledge (ioreq without rd/wr) is excluded by the rd/wr term.
            raw_io  = cpu_mreq_n && !cpu_ioreq_n && (!cpu_rd_n || !cpu_wr_n);
            raw_act = raw_act || raw_io;
`endif
        end else begin
            raw_act = cpu_phi2;
            raw_wr  = !cpu_rwb;
        end
    end

`ifndef IO_CYCLE_EN
    logic unused_ioreq;
    assign unused_ioreq = cpu_ioreq_n;
`endif

    // Synchroniser chain for {io, write, active}.
    logic [2:0] sync_d [SYNC_STAGES];
    logic [2:0] sync_q [SYNC_STAGES];

    always_comb begin
        sync_d[0] = {raw_io, raw_wr, raw_act};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    logic s_act, s_wr, s_io;
    assign {s_io, s_wr, s_act} = sync_q[SYNC_STAGES-1];

    state_e            state_d, state_q;
    logic              act_prev_d, act_prev_q;
    logic              drop_d, drop_q;
    logic [3:0]        settle_d, settle_q;
    logic [11:0]       tmo_d, tmo_q;
    logic              req_d, req_q;
    logic              wait_d, wait_q;
    logic              doe_d, doe_q;
    logic [DATA_W-1:0] dout_d, dout_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              we_d, we_q;
    logic              io_d, io_q;
    logic              err_d, err_q;
    logic              gone;

    always_comb begin
        state_d    = state_q;
        act_prev_d = s_act;
        drop_d     = drop_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        req_d      = req_q;
        wait_d     = wait_q;
        doe_d      = doe_q;
        dout_d     = dout_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        io_d       = io_q;
        err_d      = err_q;
        // The CPU has abandoned the cycle (it ignored wait) if active fell at any point in REQ.
        gone       = drop_q || !s_act;

        unique case (state_q)
            StIdle: begin
                if (s_act && !act_prev_q) begin
                    state_d  = StSettle;
                    settle_d = '0;
                end
            end
            StSettle: begin
                if (!s_act) begin
                    state_d = StIdle;
                end else if (settle_q == 4'(SETTLE_CYC - 1)) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_din;
                    we_d    = s_wr;
                    io_d    = s_io;
                    req_d   = 1'b1;
                    wait_d  = 1'b1;
                    tmo_d   = '0;
                    drop_d  = 1'b0;
                    state_d = StReq;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            StReq: begin
                if (!s_act) drop_d = 1'b1;
                // An ack in the final timeout cycle still completes the access normally.
                if (acc_ack) begin
                    req_d   = 1'b0;
                    wait_d  = 1'b0;
                    if (!we_q && !gone) begin
                        dout_d = acc_rdata;
                        doe_d  = 1'b1;
                    end
                    state_d = gone ? StIdle : StHold;
                end else if (tmo_q == 12'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    wait_d  = 1'b0;
                    if (!we_q && !gone) begin
                        dout_d = '1;
                        doe_d  = 1'b1;
                    end
                    state_d = gone ? StIdle : StHold;
                end else begin
                    tmo_d = tmo_q + 12'd1;
                end
            end
            StHold: begin
                if (!s_act) begin
                    doe_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            state_q    <= StIdle;
            act_prev_q <= 1'b0;
            drop_q     <= 1'b0;
            settle_q   <= '0;
            tmo_q      <= '0;
            req_q      <= 1'b0;
            wait_q     <= 1'b0;
            doe_q      <= 1'b0;
            dout_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            state_q    <= state_d;
            act_prev_q <= act_prev_d;
            drop_q     <= drop_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            req_q      <= req_d;
            wait_q     <= wait_d;
            doe_q      <= doe_d;
            dout_q     <= dout_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            io_q       <= io_d;
            err_q      <= err_d;
        end
    end

    assign cpu_dout    = dout_q;
    assign cpu_doe     = doe_q;
    assign cpu_wait    = wait_q;
    assign acc_req     = req_q;
    assign acc_addr    = addr_q;
    assign acc_wdata   = wdata_q;
    assign acc_we      = we_q;
    assign acc_io      = io_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_cpu_bus_frontend.sv
// Bench for cpu_bus_frontend: one Z80-mode and one 6502-mode instance share the bus inputs and
// the back end. Accesses are described by their attributes and the expected outcome (req
// length, read data, doe, sticky error) is derived from those attributes.

module tb_cpu_bus_frontend;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_rd_n, cpu_wr_n, cpu_mreq_n, cpu_ioreq_n, cpu_phi2, cpu_rwb;
    logic        acc_ack;
    logic [7:0]  acc_rdata;

    logic [7:0]  o0_dout, o1_dout, o0_wdata, o1_wdata;
    logic [15:0] o0_addr, o1_addr;
    logic        o0_doe, o0_wait, o0_req, o0_we, o0_io, o0_err;
    logic        o1_doe, o1_wait, o1_req, o1_we, o1_io, o1_err;

    always #5 clk = ~clk;

    cpu_bus_frontend #(
        .ADDR_W(16), .DATA_W(8), .CPU_MODE(0), .SYNC_STAGES(2), .SETTLE_CYC(2),
        .TIMEOUT_CYC(TIMEOUT)
    ) u_z80 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(o0_dout), .cpu_doe(o0_doe), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_mreq_n(cpu_mreq_n), .cpu_ioreq_n(cpu_ioreq_n), .cpu_phi2(cpu_phi2),
        .cpu_rwb(cpu_rwb), .cpu_wait(o0_wait), .acc_req(o0_req), .acc_addr(o0_addr),
        .acc_wdata(o0_wdata), .acc_we(o0_we), .acc_io(o0_io), .acc_ack(acc_ack),
        .acc_rdata(acc_rdata), .err_timeout(o0_err)
    );

    cpu_bus_frontend #(
        .ADDR_W(16), .DATA_W(8), .CPU_MODE(1), .SYNC_STAGES(2), .SETTLE_CYC(2),
        .TIMEOUT_CYC(TIMEOUT)
    ) u_6502 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(o1_dout), .cpu_doe(o1_doe), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_mreq_n(cpu_mreq_n), .cpu_ioreq_n(cpu_ioreq_n), .cpu_phi2(cpu_phi2),
        .cpu_rwb(cpu_rwb), .cpu_wait(o1_wait), .acc_req(o1_req), .acc_addr(o1_addr),
        .acc_wdata(o1_wdata), .acc_we(o1_we), .acc_io(o1_io), .acc_ack(acc_ack),
        .acc_rdata(acc_rdata), .err_timeout(o1_err)
    );

    // Outputs of the instance currently under test.
    bit          cur_mode;
    logic [7:0]  s_dout, s_wdata;
    logic [15:0] s_addr;
    logic        s_doe, s_wait, s_req, s_we, s_io, s_err;

    always_comb begin
        s_dout = o0_dout; s_wdata = o0_wdata; s_addr = o0_addr; s_doe = o0_doe;
        s_wait = o0_wait; s_req = o0_req; s_we = o0_we; s_io = o0_io; s_err = o0_err;
        if (cur_mode) begin
            s_dout = o1_dout; s_wdata = o1_wdata; s_addr = o1_addr; s_doe = o1_doe;
            s_wait = o1_wait; s_req = o1_req; s_we = o1_we; s_io = o1_io; s_err = o1_err;
        end
    end

    int checks = 0;
    int errors = 0;
    bit err_m [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit mode, input bit wr, input bit io, input bit on);
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_mreq_n = 1'b1; cpu_ioreq_n = 1'b1;
        cpu_phi2 = 1'b0; cpu_rwb = 1'b1;
        if (on) begin
            if (mode == 1'b0) begin
                if (io) cpu_ioreq_n = 1'b0;
                else    cpu_mreq_n  = 1'b0;
                if (wr) begin
                    cpu_wr_n = 1'b0;
                    // Occasionally both strobes low: still a write.
                    cpu_rd_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                end else begin
                    cpu_rd_n = 1'b0;
                end
            end else begin
                cpu_phi2 = 1'b1;
                cpu_rwb  = !wr;
            end
        end
    endtask

    task automatic access(input bit mode, input logic [15:0] addr, input logic [7:0] din,
                          input bit wr, input bit io, input int delay, input bit ack_en,
                          input bit drop, input logic [7:0] rd);
        bit seen, exp_req, timed_out, exp_doe;
        int n_hi, exp_hi;
        exp_req = mode || !io;
`ifdef IO_CYCLE_EN
        exp_req = 1'b1;
`endif
        cur_mode = mode;
        cpu_addr = addr;
        cpu_din  = din;
        drive(mode, wr, io, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = s_req;
        end
        chk("req_rise", {31'd0, seen}, {31'd0, exp_req});
        if (!seen || !exp_req) begin
            chk("no_wait", {31'd0, s_wait}, 32'd0);
            chk("no_doe", {31'd0, s_doe}, 32'd0);
            drive(mode, wr, io, 1'b0);
            repeat (4) @(negedge clk);
            return;
        end
        chk("acc_addr", {16'd0, s_addr}, {16'd0, addr});
        chk("acc_we", {31'd0, s_we}, {31'd0, wr});
        chk("acc_io", {31'd0, s_io}, {31'd0, (!mode && io)});
        chk("wait_in_req", {31'd0, s_wait}, 32'd1);
        if (wr) chk("acc_wdata", {24'd0, s_wdata}, {24'd0, din});
        if (drop) drive(mode, wr, io, 1'b0);

        timed_out = !ack_en || delay >= TIMEOUT;
        exp_doe   = !wr && !drop;
        n_hi = 1;
        for (int k = 0; k < 40; k++) begin
            if (ack_en && k == delay) begin
                acc_ack   = 1'b1;
                acc_rdata = rd;
            end
            @(negedge clk);
            acc_ack = 1'b0;
            if (!s_req) break;
            if (s_addr !== addr) chk("addr_stable", {16'd0, s_addr}, {16'd0, addr});
            n_hi++;
        end
        exp_hi = timed_out ? TIMEOUT : delay + 1;
        if (timed_out) err_m[mode] = 1'b1;
        chk("req_cycles", n_hi, exp_hi);
        chk("wait_drop", {31'd0, s_wait}, 32'd0);
        chk("err_timeout", {31'd0, s_err}, {31'd0, err_m[mode]});
        chk("doe_after", {31'd0, s_doe}, {31'd0, exp_doe});
        if (exp_doe) chk("rdata", {24'd0, s_dout}, timed_out ? 32'hFF : {24'd0, rd});

        if (timed_out && exp_doe) begin
            // Late ack in HOLD must not change anything.
            acc_ack   = 1'b1;
            acc_rdata = 8'h3C;
            @(negedge clk);
            acc_ack = 1'b0;
            @(negedge clk);
            chk("late_ack_dout", {24'd0, s_dout}, 32'hFF);
            chk("late_ack_doe", {31'd0, s_doe}, 32'd1);
        end

        if (!drop) begin
            drive(mode, wr, io, 1'b0);
            @(negedge clk);
            chk("doe_hold", {31'd0, s_doe}, {31'd0, exp_doe});
            for (int k = 0; k < 8 && s_doe; k++) @(negedge clk);
            chk("doe_release", {31'd0, s_doe}, 32'd0);
        end else begin
            repeat (3) @(negedge clk);
            chk("doe_never", {31'd0, s_doe}, 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit seen;
        bit use_io;
        reset = 1'b1;
        cur_mode = 1'b0;
        cpu_addr = '0; cpu_din = '0; acc_ack = 1'b0; acc_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_z80", {o0_dout, o0_doe, o0_wait, o0_req, o0_addr, o0_we, o0_io, o0_err},
            32'd0);
        chk("reset_z80_wdata", {24'd0, o0_wdata}, 32'd0);
        chk("reset_6502", {o1_dout, o1_doe, o1_wait, o1_req, o1_addr, o1_we, o1_io, o1_err},
            32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed steps.
        access(1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 3, 1'b1, 1'b0, 8'hA5);  // read
        access(1'b0, 16'h8000, 8'h5A, 1'b1, 1'b0, 2, 1'b1, 1'b0, 8'h00);  // write
        access(1'b0, 16'h4321, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00);  // timeout
        access(1'b0, 16'h0042, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 8'h77);  // err stays set
        access(1'b1, 16'h2000, 8'h00, 1'b0, 1'b0, TIMEOUT - 1, 1'b1, 1'b0, 8'h99);  // ack wins

        // Glitch shorter than the settle window.
        cur_mode = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | s_req | s_wait;
        end
        chk("glitch_no_req", {31'd0, seen}, 32'd0);

        access(1'b1, 16'hFFFC, 8'h00, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'h00);  // 6502 read
        access(1'b1, 16'hFFFD, 8'hC3, 1'b1, 1'b0, 1, 1'b1, 1'b0, 8'h00);  // 6502 write
        access(1'b0, 16'h00FE, 8'h00, 1'b0, 1'b1, 2, 1'b1, 1'b0, 8'h6E);  // I/O read
        access(1'b0, 16'h1111, 8'h00, 1'b0, 1'b0, 4, 1'b1, 1'b1, 8'h12);  // CPU ignores wait

        // Reset asserted while the request is outstanding.
        use_io = 1'b0;
`ifdef IO_CYCLE_EN
        use_io = 1'b1;
`endif
        cur_mode = 1'b0;
        cpu_addr = 16'h00FE;
        drive(1'b0, 1'b0, use_io, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = s_req;
        end
        chk("reset_test_req", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_mid_req", {s_dout, s_doe, s_wait, s_req, s_addr, s_we, s_io, s_err}, 32'd0);
        err_m[0] = 1'b0;
        err_m[1] = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Randomised accesses.
        for (int n = 0; n < 30; n++) begin
            bit m, w, a, d, i;
            int dl;
            m  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 5) != 0);
            d  = ($urandom_range(0, 5) == 0);
            i  = !m && ($urandom_range(0, 7) == 0);
            dl = d ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 5));
            access(m, 16'($urandom), 8'($urandom), w, i, dl, a, d, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
